// File: rtl/cpu_pkg.sv
// Shared CPU constants and loader state encoding.
// Used by the instruction memory, the loader and its byte assembler.
package cpu_pkg;

  localparam int NBITS_P     = 8;
  localparam int INST_BITS_P = 32;
  localparam logic [INST_BITS_P-1:0] HALT_WORD_P = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/instr_mem_loader_assembler.sv
// Serial byte to 32-bit word assembler, first byte lands in the MSB.
// Flags the fourth byte combinationally so the word is latched that edge.
module byte_to_word_assembler
  import cpu_pkg::*;
#(
  parameter int NBITS     = NBITS_P,
  parameter int INST_BITS = INST_BITS_P
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [NBITS-1:0]     i_byte,
  input  logic                 i_valid,
  output logic [INST_BITS-1:0] o_word,
  output logic                 o_word_valid
);

  logic [INST_BITS-NBITS-1:0] r_shift;
  logic [1:0]                 r_idx;
  logic                       w_take;

  assign w_take       = i_en & i_valid;
  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = w_take & (r_idx == 2'd3);

  // Shift accepted bytes in; index wraps after the fourth byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_idx   <= 2'd0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_idx   <= 2'd0;
    end else if (w_take) begin
      r_shift <= o_word[INST_BITS-NBITS-1:0];
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader and instruction-memory port arbiter.
// Writes UART words from address 0 until HALT_WORD or memory full.
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int NBITS     = NBITS_P,
  parameter int INST_BITS = INST_BITS_P,
  parameter int CELLS     = 256,
  parameter logic [INST_BITS-1:0] HALT_WORD = HALT_WORD_P
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [NBITS-1:0]           i_rx_data,
  input  logic                       i_rx_valid,
  input  logic [INST_BITS-1:0]       i_fetch_addr,
  output logic [INST_BITS-1:0]       o_mem_addr,
  output logic [INST_BITS-1:0]       o_mem_data,
  output logic                       o_mem_wr_en,
  output logic                       o_loading,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [$clog2(CELLS/4):0]   o_word_count
);

  localparam int WORDS = CELLS / 4;
  localparam int CW    = $clog2(WORDS) + 1;

  ld_state_t            r_state;
  ld_state_t            w_state_nxt;
  logic [CW-1:0]        r_count;
  logic [INST_BITS-1:0] r_mem_data;
  logic                 r_wr_en;
  logic                 r_loading;
  logic                 r_done;
  logic                 r_overflow;
  logic                 w_clear;
  logic                 w_ovf_set;
  logic                 w_asm_en;
  logic [INST_BITS-1:0] w_word;
  logic                 w_word_done;
  logic [INST_BITS-1:0] w_ld_addr;

  assign w_asm_en = (r_state == S_RECV) | (r_state == S_WRITE);

  byte_to_word_assembler #(
    .NBITS     (NBITS),
    .INST_BITS (INST_BITS)
  ) u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_clear),
    .i_en         (w_asm_en),
    .i_byte       (i_rx_data),
    .i_valid      (i_rx_valid),
    .o_word       (w_word),
    .o_word_valid (w_word_done)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, session clear and overflow detection.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_ovf_set   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_RECV;
          w_clear     = 1'b1;
        end
      end
      S_RECV: begin
        if (w_word_done) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (r_mem_data == HALT_WORD) begin
          w_state_nxt = S_DONE;
        end else if (r_count == CW'(WORDS - 1)) begin
          w_state_nxt = S_DONE;
          w_ovf_set   = 1'b1;
        end else begin
          w_state_nxt = S_RECV;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered flags, word counter and write-data latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= '0;
      r_mem_data <= '0;
      r_wr_en    <= 1'b0;
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_loading <= (w_state_nxt == S_RECV) | (w_state_nxt == S_WRITE);
      r_wr_en   <= (w_state_nxt == S_WRITE);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_clear) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (r_state == S_WRITE) r_count <= r_count + 1'b1;
        if (w_ovf_set)          r_overflow <= 1'b1;
      end
      if (w_word_done) r_mem_data <= w_word;
    end
  end

  assign w_ld_addr    = {{(INST_BITS-CW-2){1'b0}}, r_count, 2'b00};
  assign o_mem_addr   = r_loading ? w_ld_addr : i_fetch_addr;
  assign o_mem_data   = r_mem_data;
  assign o_mem_wr_en  = r_wr_en;
  assign o_loading    = r_loading;
  assign o_done       = r_done;
  assign o_overflow   = r_overflow;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
// Inputs change 1ns after rising edges; outputs sampled there too.
module tb_instr_mem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic [31:0] i_fetch_addr = 32'h10;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic        o_mem_wr_en;
  logic        o_loading;
  logic        o_done;
  logic        o_overflow;
  logic [6:0]  o_word_count;

  int total = 0;
  int bad   = 0;

  instr_mem_loader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_fetch_addr (i_fetch_addr),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_loading    (o_loading),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_fetch_addr = 32'h10;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    total++;
    if ({o_loading, o_done, o_overflow, o_mem_wr_en} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {o_loading, o_done, o_overflow, o_mem_wr_en});
    end
    total++;
    if (o_mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=00000010", o_mem_addr);
    end
    total++;
    if (o_word_count !== 7'd0 || o_mem_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%h exp=0/0", o_word_count, o_mem_data);
    end
  endtask

  task automatic test_load();
    pulse_start();
    send_word(32'h3C0A0002);
    total++;
    if ({o_mem_wr_en, o_loading} !== 2'b11 || o_mem_addr !== 32'h0
        || o_mem_data !== 32'h3C0A0002) begin
      bad++;
      $display("FAIL load_w0 got=%b%b %h %h exp=11 0 3c0a0002",
               o_mem_wr_en, o_loading, o_mem_addr, o_mem_data);
    end
    tick();
    total++;
    if (o_mem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL load_one_cycle got=%b exp=0", o_mem_wr_en);
    end
    send_word(32'h3C0A0003);
    total++;
    if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h4
        || o_mem_data !== 32'h3C0A0003) begin
      bad++;
      $display("FAIL load_w1 got=%b %h %h exp=1 4 3c0a0003",
               o_mem_wr_en, o_mem_addr, o_mem_data);
    end
    send_word(32'hFFFFFFFF);
    total++;
    if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h8
        || o_mem_data !== 32'hFFFFFFFF) begin
      bad++;
      $display("FAIL load_halt got=%b %h %h exp=1 8 ffffffff",
               o_mem_wr_en, o_mem_addr, o_mem_data);
    end
    tick();
    total++;
    if ({o_done, o_loading, o_mem_wr_en, o_overflow} !== 4'b1000
        || o_word_count !== 7'd3 || o_mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL load_done got=%b cnt=%0d addr=%h exp=1000 cnt=3 addr=10",
               {o_done, o_loading, o_mem_wr_en, o_overflow},
               o_word_count, o_mem_addr);
    end
  endtask

  task automatic test_overflow();
    int writes;
    pulse_start();
    total++;
    if (o_done !== 1'b0 || o_word_count !== 7'd0 || o_loading !== 1'b1) begin
      bad++;
      $display("FAIL ovf_restart got=%b/%0d/%b exp=0/0/1",
               o_done, o_word_count, o_loading);
    end
    for (int n = 0; n < 64; n++) begin
      send_word(32'h3C0A0000 + n);
      if (n == 63) begin
        total++;
        if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'hFC
            || o_mem_data !== 32'h3C0A003F) begin
          bad++;
          $display("FAIL ovf_last got=%b %h %h exp=1 fc 3c0a003f",
                   o_mem_wr_en, o_mem_addr, o_mem_data);
        end
      end
    end
    tick();
    total++;
    if ({o_done, o_overflow, o_loading} !== 3'b110 || o_word_count !== 7'd64) begin
      bad++;
      $display("FAIL ovf_flags got=%b cnt=%0d exp=110 cnt=64",
               {o_done, o_overflow, o_loading}, o_word_count);
    end
    writes = 0;
    for (int k = 0; k < 6; k++) begin
      send_byte(8'h11);
      if (o_mem_wr_en) writes++;
    end
    total++;
    if (writes != 0 || o_word_count !== 7'd64) begin
      bad++;
      $display("FAIL ovf_ignore got=%0d writes cnt=%0d exp=0 cnt=64",
               writes, o_word_count);
    end
    pulse_start();
    total++;
    if ({o_done, o_overflow, o_loading} !== 3'b001 || o_word_count !== 7'd0) begin
      bad++;
      $display("FAIL ovf_clear got=%b cnt=%0d exp=001 cnt=0",
               {o_done, o_overflow, o_loading}, o_word_count);
    end
  endtask

  task automatic test_reset_midword();
    send_byte(8'h12);
    send_byte(8'h34);
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_loading, o_mem_wr_en, o_done} !== 3'b000 || o_word_count !== 7'd0) begin
      bad++;
      $display("FAIL rst_mid got=%b cnt=%0d exp=000 cnt=0",
               {o_loading, o_mem_wr_en, o_done}, o_word_count);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    i_start    = 1'b1;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hAA;
    tick();
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    send_word(32'h3C0A0005);
    total++;
    if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h0
        || o_mem_data !== 32'h3C0A0005) begin
      bad++;
      $display("FAIL rst_reload got=%b %h %h exp=1 0 3c0a0005",
               o_mem_wr_en, o_mem_addr, o_mem_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w2;
    send_word(32'hFFFFFFFF);
    tick();
    pulse_start();
    send_byte(8'h3C);
    send_byte(8'h0A);
    send_byte(8'h00);
    tick();
    i_rx_data  = 8'h01;
    i_rx_valid = 1'b1;
    w2 = 32'h3C0A0004;
    for (int k = 0; k < 4; k++) begin
      tick();
      i_rx_data = w2[31:24];
      w2 = w2 << 8;
      if (k == 0) begin
        total++;
        if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h0
            || o_mem_data !== 32'h3C0A0001) begin
          bad++;
          $display("FAIL b2b_w1 got=%b %h %h exp=1 0 3c0a0001",
                   o_mem_wr_en, o_mem_addr, o_mem_data);
        end
      end
    end
    tick();
    i_rx_valid = 1'b0;
    total++;
    if (o_mem_wr_en !== 1'b1 || o_mem_addr !== 32'h4
        || o_mem_data !== 32'h3C0A0004) begin
      bad++;
      $display("FAIL b2b_w2 got=%b %h %h exp=1 4 3c0a0004",
               o_mem_wr_en, o_mem_addr, o_mem_data);
    end
    tick();
    total++;
    if (o_word_count !== 7'd2 || o_loading !== 1'b1) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d/%b exp=2/1", o_word_count, o_loading);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_reset_midword();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
